// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;
    localparam int          NUM_ITER      = 32;

    function automatic logic a_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the register-file read ports and the muldiv unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_cond_negate.sv
// Combinational two's-complement negate of a WIDTH-bit value when neg is set.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -value : value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, then sign fix-up.
// Build option MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int             CNT_W     = $clog2(NUM_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER - 1);

    state_t             state, state_next, entry_state;
    muldiv_op_t         op_q, op_in;
    logic               sa_q, sb_q, spec_q;
    logic [WIDTH-1:0]   operand_q, spec_val_q, result_q;
    logic [2*WIDTH-1:0] acc_q, acc_iter;
    logic [CNT_W-1:0]   cnt_q;

    logic               sa_in, sb_in, is_div_in, div0_in, ovf_in, spec_in, accept;
    logic [WIDTH-1:0]   mag_a, mag_b, spec_val_in;

    assign op_in     = muldiv_op_t'(bus.funct3);
    assign sa_in     = a_signed(op_in) && bus.op_a[WIDTH-1];
    assign sb_in     = b_signed(op_in) && bus.op_b[WIDTH-1];
    assign is_div_in = bus.funct3[2];
    assign div0_in   = is_div_in && (bus.op_b == '0);
    assign ovf_in    = (op_in == OP_DIV || op_in == OP_REM)
                       && (bus.op_a == SIGNED_MIN) && (bus.op_b == '1);
    assign spec_in   = div0_in || ovf_in;
    assign accept    = bus.start && (state == IDLE || state == DONE);

    // funct3[1] separates REM/REMU from DIV/DIVU among the divide ops.
    always_comb begin
        spec_val_in = '0;
        if (div0_in)
            spec_val_in = bus.funct3[1] ? bus.op_a : DIV0_QUOTIENT;
        else if (!bus.funct3[1])
            spec_val_in = SIGNED_MIN;
    end

    cond_negate #(.WIDTH(WIDTH)) u_neg_a (.value(bus.op_a), .neg(sa_in), .y(mag_a));
    cond_negate #(.WIDTH(WIDTH)) u_neg_b (.value(bus.op_b), .neg(sb_in), .y(mag_b));

`ifdef MULDIV_EARLY_OUT_EN
    assign entry_state = spec_in ? FIX : CALC;
`else
    assign entry_state = CALC;
`endif

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: assign every combinational output a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = entry_state;
            CALC:    if (cnt_q == LAST_ITER) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = bus.start ? entry_state : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    logic [WIDTH:0]   mul_sum, rem_shift;
    logic [WIDTH-1:0] addend, div_diff, rem_next;
    logic             div_ge;

    always_comb begin
        addend    = acc_q[0] ? operand_q : '0;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = rem_shift[WIDTH-1:0] - operand_q;
        div_ge    = rem_shift[WIDTH] || (rem_shift[WIDTH-1:0] >= operand_q);
        rem_next  = div_ge ? div_diff : rem_shift[WIDTH-1:0];
        if (op_q[2]) acc_iter = {rem_next, acc_q[WIDTH-2:0], div_ge};
        else         acc_iter = {mul_sum, acc_q[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_val;

    cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.value(acc_q), .neg(sa_q ^ sb_q), .y(prod_fix));
    cond_negate #(.WIDTH(WIDTH)) u_neg_quot (.value(acc_q[WIDTH-1:0]), .neg(sa_q ^ sb_q), .y(quot_fix));
    cond_negate #(.WIDTH(WIDTH)) u_neg_rem (.value(acc_q[2*WIDTH-1:WIDTH]), .neg(sa_q), .y(rem_fix));

    always_comb begin
        fix_val = rem_fix;
        case (op_q)
            OP_MUL:                       fix_val = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_val = quot_fix;
            default:                      fix_val = rem_fix;
        endcase
        if (spec_q) fix_val = spec_val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_MUL;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            spec_q     <= 1'b0;
            operand_q  <= '0;
            spec_val_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else if (accept) begin
            op_q       <= op_in;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            spec_q     <= spec_in;
            spec_val_q <= spec_val_in;
            operand_q  <= is_div_in ? mag_b : mag_a;
            acc_q      <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
            cnt_q      <= '0;
        end else if (state == CALC) begin
            acc_q      <= acc_iter;
            cnt_q      <= cnt_q + CNT_W'(1);
        end else if (state == FIX) begin
            result_q   <= fix_val;
        end
    end

    assign bus.busy   = (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: edge-level reference model plus directed and random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int          ai, bi;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        ua  = {32'b0, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ai  = a;
        bi  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ai / bi);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(ai % bi);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int op_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic special;
        special = (f[2] && b == 0) || (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? SPECIAL_LAT : 33;
    endfunction

    // Edge-indexed model: an op accepted at edge e completes at edge d = e + latency.
    int          cyc    = 0;
    int          e_edge = -1;
    int          d_edge = -1;
    logic [31:0] cur_res  = '0;
    logic [31:0] pend_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_edge  = -1;
            d_edge  = -1;
            cur_res = '0;
        end else begin
            cyc++;
            if (cyc == d_edge) cur_res = pend_res;
            if (bus.start && cyc > d_edge) begin
                e_edge   = cyc;
                d_edge   = cyc + op_latency(bus.funct3, bus.op_a, bus.op_b);
                pend_res = ref_result(bus.funct3, bus.op_a, bus.op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'b0, bus.busy}, {31'b0, (cyc >= e_edge && cyc < d_edge)});
            check("done", {31'b0, bus.done}, {31'b0, (cyc == d_edge)});
            check("result", bus.result, cur_res);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
    endtask

    task automatic wait_done(output int n, output logic [31:0] res, input bit junk);
        n = 0;
        while (!bus.done && n < 100) begin
            if (junk && bus.busy && $urandom_range(0, 3) == 0) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'($urandom);
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("done seen", {31'b0, bus.done}, 32'd1);
        res = bus.result;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int          n;
        logic [31:0] res;
        check({name, " model"}, ref_result(f, a, b), exp);
        issue(f, a, b);
        wait_done(n, res, 1'b0);
        check({name, " result"}, res, exp);
        check({name, " latency"}, n, exp_lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, n2;
        logic [31:0] res, res2;
        logic [2:0]  f;
        logic [31:0] a, b;

        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIV by 0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("REMU by 0", OP_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPECIAL_LAT);

        // start during CALC with different operands must not disturb the running op
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.funct3 = OP_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(n, res, 1'b0);
        check("ignored start result", res, 32'd14);
        check("ignored start latency", n + 11, 32'd33);

        // back-to-back: second start presented during DONE
        issue(OP_MUL, 32'd3, 32'd4);
        wait_done(n, res, 1'b0);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(n2, res2, 1'b0);
        check("b2b first", res, 32'd12);
        check("b2b second", res2, 32'd14);
        check("b2b done gap", n2 + 1, 32'd34);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            issue(f, a, b);
            wait_done(n, res, 1'b1);
            check("random result", res, ref_result(f, a, b));
            check("random latency", n, op_latency(f, a, b));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // asynchronous reset in the middle of CALC
        run_op("MULHU pre-reset", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        issue(OP_MUL, 32'd5, 32'd6);
        repeat (15) @(negedge clk);
        check("pre-reset busy", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'b0, bus.busy}, 32'd0);
        check("mid reset done", {31'b0, bus.done}, 32'd0);
        check("mid reset result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op("MUL after reset", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
